fifo_sync_param: RTL and testbench

- Parametrised single-clock synchronous FIFO. It is the next generation of the team's 16-bit, 2-entry command FIFO.
- It sits between the host/SPI command decoder and the motor step generators, buffering step/direction command words per axis.
- Adds:
  - configurable width and depth;
  - almost-full and almost-empty thresholds;
  - a full-with-read write pass-through;
  - synchronous flush;
  - sticky overflow/underflow error flags.

---
 rtl/fifo_sync_param_if.sv | 32 +++
 rtl/fifo_sync_param.sv | 111 +++++++++++
 tb/tb_fifo_sync_param.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_param_if.sv
// rtl/fifo_sync_param_if.sv - Bus bundle for fifo_sync_param: write/read handshake, control and status.
interface fifo_sync_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr_en, din, rd_en, clr_err,
    input  dout, dout_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, din, rd_en, clr_err,
    output dout, dout_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - Parametrised single-clock command FIFO with thresholds, flush and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module fifo_sync_param #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input logic              clk,
  input logic              rst,
  fifo_sync_param_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic              empty_w;
  logic              full_w;
  logic              rd_acc;
  logic              wr_acc;
  logic              rd_go;
  logic              wr_go;
  logic              ovf_q;
  logic              unf_q;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_C);

  // A full FIFO still takes a write when a read frees the slot in the same cycle.
  assign rd_acc = bus.rd_en & ~empty_w;
  assign wr_acc = bus.wr_en & (~full_w | rd_acc);

  // Flush drops both requests outright: no state movement and no error.
  assign rd_go = rd_acc & ~bus.flush;
  assign wr_go = wr_acc & ~bus.flush;

  always_comb begin
    count_d = count_q;
    case ({wr_go, rd_go})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_go) wr_ptr <= wr_ptr + 1'b1;
      if (rd_go) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go) mem[wr_ptr] <= bus.din;
  end

  // Set beats clear so an error in the clr_err cycle is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~bus.clr_err) | (bus.wr_en & ~wr_acc & ~bus.flush);
      unf_q <= (unf_q & ~bus.clr_err) | (bus.rd_en & ~rd_acc & ~bus.flush);
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.dout       = mem[rd_ptr];
  assign bus.dout_valid = ~empty_w;
`else
  logic [DATA_W-1:0] dout_q;
  logic              dout_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= rd_go;
      if (rd_go) dout_q <= mem[rd_ptr];
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
`endif

  assign bus.count        = count_q;
  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.almost_empty = (count_q <= AEMPTY_C);
  assign bus.almost_full  = (count_q >= AFULL_C);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - Self-checking bench for fifo_sync_param against a queue-based reference.
module tb_fifo_sync_param;
  localparam int DW        = 16;
  localparam int AW        = 4;
  localparam int DEPTH     = 16;
  localparam int AFULL_TH  = 12;
  localparam int AEMPTY_TH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  fifo_sync_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  fifo_sync_param #(
    .DATA_W(DW), .ADDR_W(AW), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_valid;
  logic          m_ovf;
  logic          m_unf;
  logic [DW-1:0] seq_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic model_update(input logic w, input logic [DW-1:0] d, input logic r,
                              input logic f, input logic c);
    bit rd_ok;
    bit wr_ok;
    if (c) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (f) begin
      q.delete();
      m_valid = 1'b0;
    end else begin
      rd_ok = r && (q.size() > 0);
      wr_ok = w && ((q.size() < DEPTH) || rd_ok);
      if (rd_ok) begin
        m_dout  = q.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (wr_ok) q.push_back(d);
      if (w && !wr_ok) m_ovf = 1'b1;
      if (r && !rd_ok) m_unf = 1'b1;
    end
  endtask

  task automatic check_all(input string ph);
    int n;
    n = q.size();
    chk({ph, ":count"},        32'(bus.count),        32'(n));
    chk({ph, ":empty"},        32'(bus.empty),        32'(n == 0));
    chk({ph, ":full"},         32'(bus.full),         32'(n == DEPTH));
    chk({ph, ":almost_empty"}, 32'(bus.almost_empty), 32'(n <= AEMPTY_TH));
    chk({ph, ":almost_full"},  32'(bus.almost_full),  32'(n >= AFULL_TH));
    chk({ph, ":overflow"},     32'(bus.overflow),     32'(m_ovf));
    chk({ph, ":underflow"},    32'(bus.underflow),    32'(m_unf));
`ifdef FIFO_FWFT_EN
    chk({ph, ":dout_valid"},   32'(bus.dout_valid),   32'(n != 0));
    if (n != 0) chk({ph, ":dout"}, 32'(bus.dout), 32'(q[0]));
`else
    chk({ph, ":dout_valid"},   32'(bus.dout_valid),   32'(m_valid));
    chk({ph, ":dout"},         32'(bus.dout),         32'(m_dout));
`endif
  endtask

  task automatic step(input string ph, input logic w, input logic [DW-1:0] d, input logic r,
                      input logic f, input logic c);
    bus.wr_en   = w;
    bus.din     = d;
    bus.rd_en   = r;
    bus.flush   = f;
    bus.clr_err = c;
    @(posedge clk);
    model_update(w, d, r, f, c);
    #1;
    check_all(ph);
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;
    bus.din     = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_all("reset");
    chk("reset:count_zero", 32'(bus.count), 32'd0);
    chk("reset:empty_one",  32'(bus.empty), 32'd1);

    // Fill with 0x0001..0x0010
    for (int i = 1; i <= 16; i++) begin
      step("fill", 1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
      chk("fill:afull_edge", 32'(bus.almost_full), 32'(i >= 12));
    end
    chk("fill:count16",   32'(bus.count),    32'd16);
    chk("fill:full",      32'(bus.full),     32'd1);
    chk("fill:overflow0", 32'(bus.overflow), 32'd0);

    step("ovf", 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
    chk("ovf:flag",    32'(bus.overflow), 32'd1);
    chk("ovf:count16", 32'(bus.count),    32'd16);

    // Full with simultaneous read and write
    step("fullrw", 1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0);
    chk("fullrw:dout",  32'(bus.dout),  32'h0001);
    chk("fullrw:count", 32'(bus.count), 32'd16);

    for (int i = 0; i < 16; i++) step("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("drain:last", 32'(bus.dout),  32'h00AA);
    chk("drain:empty", 32'(bus.empty), 32'd1);

    // Empty with simultaneous read and write
    step("clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("clr:overflow0", 32'(bus.overflow), 32'd0);
    step("emptyrw", 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
    chk("emptyrw:underflow", 32'(bus.underflow), 32'd1);
    chk("emptyrw:count",     32'(bus.count),     32'd1);
    step("emptyrw_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("emptyrw_rd:dout",  32'(bus.dout),       32'h1234);
    chk("emptyrw_rd:valid", 32'(bus.dout_valid), 32'd1);

    // Wrap-around at count 3
    seq_d = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      step("wrap_pre", 1'b1, seq_d, 1'b0, 1'b0, 1'b0);
      seq_d = seq_d + 1'b1;
    end
    for (int i = 0; i < 40; i++) begin
      step("wrap", 1'b1, seq_d, 1'b1, 1'b0, 1'b0);
      seq_d = seq_d + 1'b1;
    end
    chk("wrap:count3", 32'(bus.count), 32'd3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand",
           1'($urandom_range(0, 99) < 55),
           16'($urandom),
           1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 3),
           1'($urandom_range(0, 99) < 5));
    end

    // Flush with a concurrent write
    step("pre_flush", 1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step("fl_fill", 1'b1, 16'(16'h0C00 + i), 1'b0, 1'b0, 1'b0);
    step("fl_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step("flush", 1'b1, 16'h5555, 1'b0, 1'b1, 1'b0);
    chk("flush:count",    32'(bus.count),    32'd0);
    chk("flush:empty",    32'(bus.empty),    32'd1);
    chk("flush:overflow", 32'(bus.overflow), 32'd0);
`ifndef FIFO_FWFT_EN
    chk("flush:dout_kept", 32'(bus.dout), 32'h0C00);
`endif

    // Asynchronous reset mid-stream at count 7
    step("pre_rst_unf", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step("rst_fill", 1'b1, 16'(16'h0700 + i), 1'b0, 1'b0, 1'b0);
    step("rst_rd", 1'b1, 16'h0707, 1'b1, 1'b0, 1'b0);
    chk("rst_fill:count7", 32'(bus.count), 32'd7);
    #2 rst = 1'b1;
    #1;
    chk("async_rst:count",     32'(bus.count),      32'd0);
    chk("async_rst:empty",     32'(bus.empty),      32'd1);
    chk("async_rst:full",      32'(bus.full),       32'd0);
    chk("async_rst:underflow", 32'(bus.underflow),  32'd0);
    chk("async_rst:overflow",  32'(bus.overflow),   32'd0);
    chk("async_rst:valid",     32'(bus.dout_valid), 32'd0);
`ifndef FIFO_FWFT_EN
    chk("async_rst:dout",      32'(bus.dout),       32'd0);
`endif
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    step("clr_idle", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("clr_idle:overflow",  32'(bus.overflow),  32'd0);
    chk("clr_idle:underflow", 32'(bus.underflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
